// File: rtl/sprite_frame_scheduler.sv
`timescale 1ns/1ps
// sprite_frame_scheduler
// Purpose: per-frame game-state sequencer for the VGA sprite path. Counts
// falling vsync edges and, every FRAME_DIV frames, runs a five-step update:
// latch/clamp the bird height, scroll/respawn the pipe pair, build bounding
// boxes, test collision and scoring, then publish all results in one cycle.
//
// Ports:
//   iVGA_CLK      in   1   pixel clock (only clock)
//   rst           in   1   asynchronous active-high reset
//   iVS           in   1   active-low vsync
//   bird_y_long   in  32   processor bird top, two's complement
//   iRun          in   1   1 = pipes scroll
//   oBird_*       out 19   bird box (left/right/top/bottom)
//   oUpper_*      out 19   upper pipe box (left/right/bottom), top is 0
//   oLower_*      out 19   lower pipe box (left/right/top), bottom is SCREEN_H-1
//   oPipe_vis     out  1   pipe pair intersects the screen
//   oUpdate       out  1   one-cycle pulse on the publish edge
//   oCollide      out  1   sticky collision flag
//   oScore        out  8   pipes passed, wraps 255->0
//
// Build option: define PIPE_RANDOM_GAP_EN to draw respawn gap heights from a
// 16-bit LFSR; otherwise respawn uses GAP_Y_DEFAULT and no LFSR is built.

module sprite_frame_scheduler #(
    parameter int unsigned SCREEN_W      = 640,
    parameter int unsigned SCREEN_H      = 480,
    parameter int unsigned BIRD_X        = 320,
    parameter int unsigned BIRD_W        = 45,
    parameter int unsigned BIRD_H        = 35,
    parameter int unsigned PIPE_W        = 54,
    parameter int unsigned GAP           = 50,
    parameter int unsigned FRAME_DIV     = 30,
    parameter int unsigned SCROLL_STEP   = 2,
    parameter int unsigned GAP_Y_DEFAULT = 200,
    parameter int unsigned GAP_Y_MIN     = 80,
    parameter int unsigned GAP_Y_MAX     = 400
) (
    input  logic        iVGA_CLK,
    input  logic        rst,
    input  logic        iVS,
    input  logic [31:0] bird_y_long,
    input  logic        iRun,
    output logic [18:0] oBird_left,
    output logic [18:0] oBird_right,
    output logic [18:0] oBird_top,
    output logic [18:0] oBird_bottom,
    output logic [18:0] oUpper_left,
    output logic [18:0] oUpper_right,
    output logic [18:0] oUpper_bottom,
    output logic [18:0] oLower_left,
    output logic [18:0] oLower_right,
    output logic [18:0] oLower_top,
    output logic        oPipe_vis,
    output logic        oUpdate,
    output logic        oCollide,
    output logic [7:0]  oScore
);

    localparam int unsigned W = 19;

    localparam logic [W-1:0] X_BIRD_L    = W'(BIRD_X);
    localparam logic [W-1:0] X_BIRD_R    = W'(BIRD_X + BIRD_W);
    localparam logic [W-1:0] H_BIRD      = W'(BIRD_H);
    localparam logic [W-1:0] Y_TOP_MAX   = W'(SCREEN_H - 1 - BIRD_H);
    localparam logic [W-1:0] Y_GROUND    = W'(SCREEN_H - 1);
    localparam logic [W-1:0] X_RIGHT_MAX = W'(SCREEN_W - 1);
    localparam logic [W-1:0] X_SCREEN    = W'(SCREEN_W);
    localparam logic [W-1:0] HALF_PIPE   = W'(PIPE_W / 2);
    localparam logic [W-1:0] HALF_GAP    = W'(GAP / 2);
    localparam logic [W-1:0] STEP        = W'(SCROLL_STEP);
    localparam logic [W-1:0] RESPAWN_LIM = W'(SCROLL_STEP + PIPE_W / 2);
    localparam logic [W-1:0] SPAWN_X     = W'(SCREEN_W + PIPE_W / 2);
    localparam logic [7:0]   DIV_LAST    = 8'(FRAME_DIV - 1);
    // Reset gap is held inside the random gap range so both builds share it.
    localparam int unsigned  GAP_RESET_I = (GAP_Y_DEFAULT < GAP_Y_MIN) ? GAP_Y_MIN :
                                           (GAP_Y_DEFAULT > GAP_Y_MAX) ? GAP_Y_MAX :
                                           GAP_Y_DEFAULT;
    localparam logic [W-1:0] GAP_RESET   = W'(GAP_RESET_I);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_MOVE, S_BOX, S_CHECK, S_PUBLISH
    } state_t;

    state_t       state_q;
    logic         ivs_d_q;
    logic         start_q;
    logic [7:0]   frame_cnt_q;
    logic [W-1:0] y_q;
    logic [W-1:0] pipe_x_q;
    logic [W-1:0] gap_y_q;
    logic [7:0]   score_q;
    logic         collide_q;
    logic [W-1:0] bird_top_q;
    logic [W-1:0] bird_bottom_q;
    logic [W-1:0] pipe_left_q;
    logic [W-1:0] pipe_right_q;
    logic [W-1:0] upper_bottom_q;
    logic [W-1:0] lower_top_q;
    logic         pipe_vis_q;

    logic         vs_fall_c;
    logic [W-1:0] y_d;
    logic [W-1:0] step_x_c;
    logic [W-1:0] pipe_x_d;
    logic [W-1:0] gap_y_d;
    logic [7:0]   score_d;
    logic [W-1:0] right_sum_c;
    logic [W-1:0] pipe_left_d;
    logic [W-1:0] pipe_right_d;
    logic [W-1:0] upper_bottom_d;
    logic [W-1:0] lower_top_d;
    logic [W-1:0] bird_bottom_d;
    logic         pipe_vis_d;
    logic         hit_c;
    logic [W-1:0] gap_new_c;

    assign vs_fall_c = ivs_d_q & ~iVS;

`ifdef PIPE_RANDOM_GAP_EN
    localparam logic [8:0] GAP_SPAN = 9'(GAP_Y_MAX - GAP_Y_MIN);

    logic [15:0] lfsr_q;
    logic [8:0]  gap_r_c;

    // Free-running Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
    always_ff @(posedge iVGA_CLK or posedge rst) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    // Single fold of a 9-bit draw into the gap span; span+1 > 255 keeps it in range.
    always_comb begin
        gap_r_c = lfsr_q[8:0];
        if (gap_r_c > GAP_SPAN) begin
            gap_r_c = gap_r_c - (GAP_SPAN + 9'd1);
        end
        gap_new_c = W'(GAP_Y_MIN) + W'(gap_r_c);
    end
`else
    assign gap_new_c = GAP_RESET;
`endif

    // Bird height clamp: negative -> 0, below the ground line -> last legal row.
    always_comb begin
        if (bird_y_long[31]) begin
            y_d = '0;
        end else if (bird_y_long[30:0] > 31'(Y_TOP_MAX)) begin
            y_d = Y_TOP_MAX;
        end else begin
            y_d = bird_y_long[18:0];
        end
    end

    // Pipe scroll, score on crossing the bird's left edge, respawn near the left border.
    always_comb begin
        step_x_c = pipe_x_q - STEP;
        pipe_x_d = pipe_x_q;
        gap_y_d  = gap_y_q;
        score_d  = score_q;
        if (iRun && !oCollide) begin
            if (pipe_x_q < RESPAWN_LIM) begin
                pipe_x_d = SPAWN_X;
                gap_y_d  = gap_new_c;
            end else begin
                pipe_x_d = step_x_c;
                if ((pipe_x_q >= X_BIRD_L) && (step_x_c < X_BIRD_L)) begin
                    score_d = score_q + 8'd1;
                end
            end
        end
    end

    // Bounding boxes, saturated before any subtraction can wrap.
    always_comb begin
        right_sum_c    = pipe_x_q + HALF_PIPE;
        pipe_left_d    = (pipe_x_q < HALF_PIPE) ? '0 : (pipe_x_q - HALF_PIPE);
        pipe_right_d   = (right_sum_c > X_RIGHT_MAX) ? X_RIGHT_MAX : right_sum_c;
        upper_bottom_d = (gap_y_q < HALF_GAP) ? '0 : (gap_y_q - HALF_GAP);
        lower_top_d    = gap_y_q + HALF_GAP;
        bird_bottom_d  = y_q + H_BIRD;
        pipe_vis_d     = (pipe_left_d < X_SCREEN);
    end

    // Pipe hit or ground hit, evaluated on the registered boxes.
    always_comb begin
        hit_c = (pipe_vis_q && (X_BIRD_R >= pipe_left_q) && (X_BIRD_L <= pipe_right_q) &&
                 ((bird_top_q <= upper_bottom_q) || (bird_bottom_q >= lower_top_q))) ||
                (bird_bottom_q >= Y_GROUND);
    end

    // Frame counter, update sequencer and published outputs.
    always_ff @(posedge iVGA_CLK or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            ivs_d_q        <= 1'b1;
            start_q        <= 1'b0;
            frame_cnt_q    <= '0;
            y_q            <= '0;
            pipe_x_q       <= SPAWN_X;
            gap_y_q        <= GAP_RESET;
            score_q        <= '0;
            collide_q      <= 1'b0;
            bird_top_q     <= '0;
            bird_bottom_q  <= '0;
            pipe_left_q    <= '0;
            pipe_right_q   <= '0;
            upper_bottom_q <= '0;
            lower_top_q    <= '0;
            pipe_vis_q     <= 1'b0;
            oBird_left     <= '0;
            oBird_right    <= '0;
            oBird_top      <= '0;
            oBird_bottom   <= '0;
            oUpper_left    <= '0;
            oUpper_right   <= '0;
            oUpper_bottom  <= '0;
            oLower_left    <= '0;
            oLower_right   <= '0;
            oLower_top     <= '0;
            oPipe_vis      <= 1'b0;
            oUpdate        <= 1'b0;
            oCollide       <= 1'b0;
            oScore         <= '0;
        end else begin
            ivs_d_q <= iVS;
            start_q <= 1'b0;
            oUpdate <= 1'b0;

            // Frames are always counted; a wrap only starts an idle sequencer.
            if (vs_fall_c) begin
                if (frame_cnt_q == DIV_LAST) begin
                    frame_cnt_q <= '0;
                    start_q     <= (state_q == S_IDLE);
                end else begin
                    frame_cnt_q <= frame_cnt_q + 8'd1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start_q) begin
                        state_q <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    y_q     <= y_d;
                    state_q <= S_MOVE;
                end
                S_MOVE: begin
                    pipe_x_q <= pipe_x_d;
                    gap_y_q  <= gap_y_d;
                    score_q  <= score_d;
                    state_q  <= S_BOX;
                end
                S_BOX: begin
                    bird_top_q     <= y_q;
                    bird_bottom_q  <= bird_bottom_d;
                    pipe_left_q    <= pipe_left_d;
                    pipe_right_q   <= pipe_right_d;
                    upper_bottom_q <= upper_bottom_d;
                    lower_top_q    <= lower_top_d;
                    pipe_vis_q     <= pipe_vis_d;
                    state_q        <= S_CHECK;
                end
                S_CHECK: begin
                    collide_q <= collide_q | hit_c;
                    state_q   <= S_PUBLISH;
                end
                S_PUBLISH: begin
                    oBird_left    <= X_BIRD_L;
                    oBird_right   <= X_BIRD_R;
                    oBird_top     <= bird_top_q;
                    oBird_bottom  <= bird_bottom_q;
                    oUpper_left   <= pipe_left_q;
                    oUpper_right  <= pipe_right_q;
                    oUpper_bottom <= upper_bottom_q;
                    oLower_left   <= pipe_left_q;
                    oLower_right  <= pipe_right_q;
                    oLower_top    <= lower_top_q;
                    oPipe_vis     <= pipe_vis_q;
                    oCollide      <= collide_q;
                    oScore        <= score_q;
                    oUpdate       <= 1'b1;
                    state_q       <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
`timescale 1ns/1ps
// Bench for sprite_frame_scheduler: two instances (FRAME_DIV 30 and 1) share
// stimulus; a reference model pushes expected published records to a queue
// and each publish pulse pops and compares one record.

module tb_sprite_frame_scheduler;

    localparam int NF = 13;
    localparam int F_BT = 2, F_BB = 3, F_UL = 4, F_UR = 5, F_LT = 9, F_VIS = 10, F_COL = 11, F_SC = 12;

    typedef logic [NF*19-1:0] exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ivs = 1'b1;
    logic [31:0] bird_y = 32'd0;
    logic        irun = 1'b1;
    logic        sel = 1'b0;

    logic [18:0] a_bl, a_br, a_bt, a_bb, a_ul, a_ur, a_ub, a_ll, a_lr, a_lt;
    logic [18:0] b_bl, b_br, b_bt, b_bb, b_ul, b_ur, b_ub, b_ll, b_lr, b_lt;
    logic        a_vis, a_upd, a_col, b_vis, b_upd, b_col;
    logic [7:0]  a_sc, b_sc;
    exp_t        pk_a, pk_b, pk;
    logic        o_upd;

    always #5 clk = ~clk;

    sprite_frame_scheduler #(.FRAME_DIV(30)) dut_a (
        .iVGA_CLK(clk), .rst(rst), .iVS(ivs), .bird_y_long(bird_y), .iRun(irun),
        .oBird_left(a_bl), .oBird_right(a_br), .oBird_top(a_bt), .oBird_bottom(a_bb),
        .oUpper_left(a_ul), .oUpper_right(a_ur), .oUpper_bottom(a_ub),
        .oLower_left(a_ll), .oLower_right(a_lr), .oLower_top(a_lt),
        .oPipe_vis(a_vis), .oUpdate(a_upd), .oCollide(a_col), .oScore(a_sc));

    sprite_frame_scheduler #(.FRAME_DIV(1)) dut_b (
        .iVGA_CLK(clk), .rst(rst), .iVS(ivs), .bird_y_long(bird_y), .iRun(irun),
        .oBird_left(b_bl), .oBird_right(b_br), .oBird_top(b_bt), .oBird_bottom(b_bb),
        .oUpper_left(b_ul), .oUpper_right(b_ur), .oUpper_bottom(b_ub),
        .oLower_left(b_ll), .oLower_right(b_lr), .oLower_top(b_lt),
        .oPipe_vis(b_vis), .oUpdate(b_upd), .oCollide(b_col), .oScore(b_sc));

    assign pk_a  = {a_bl, a_br, a_bt, a_bb, a_ul, a_ur, a_ub, a_ll, a_lr, a_lt,
                    19'(a_vis), 19'(a_col), 19'(a_sc)};
    assign pk_b  = {b_bl, b_br, b_bt, b_bb, b_ul, b_ur, b_ub, b_ll, b_lr, b_lt,
                    19'(b_vis), 19'(b_col), 19'(b_sc)};
    assign pk    = sel ? pk_b : pk_a;
    assign o_upd = sel ? b_upd : a_upd;

    string fname [NF] = '{"bird_left", "bird_right", "bird_top", "bird_bottom",
                          "upper_left", "upper_right", "upper_bottom",
                          "lower_left", "lower_right", "lower_top",
                          "pipe_vis", "collide", "score"};

    int   vectors = 0;
    int   miscompares = 0;
    int   cur_div = 30;
    int   bfc = 0;
    int   n_upd = 0;
    int   dut_pulses = 0;
    exp_t sbq [$];

    // Reference model state
    int m_px, m_gy, m_score, m_count, m_first;
    bit m_coll, m_resp;

    logic [15:0] tb_lfsr;
    always @(posedge clk or posedge rst) begin
        if (rst) tb_lfsr <= 16'hACE1;
        else     tb_lfsr <= {tb_lfsr[14:0], tb_lfsr[15] ^ tb_lfsr[13] ^ tb_lfsr[12] ^ tb_lfsr[10]};
    end

    function automatic logic [18:0] fld(input int i);
        return pk[(NF-1-i)*19 +: 19];
    endfunction

    function automatic int clamp_y(input logic [31:0] v);
        if (v[31]) return 0;
        if (v > 32'd444) return 444;
        return int'(v[18:0]);
    endfunction

    task automatic model_reset();
        m_px = 667; m_gy = 200; m_score = 0; m_coll = 1'b0;
        m_resp = 1'b0; m_count = 0; m_first = 0;
    endtask

    // One full update of the reference model; pushes the expected publish.
    task automatic model_update();
        int y, pl, pr, ub, lt, bb;
        bit vis, hit;
        logic [8:0] r;
        exp_t e;
        m_count++;
        m_resp = 1'b0;
        y = clamp_y(bird_y);
        if (irun && !m_coll) begin
            if (m_px < 29) begin
                m_px = 667;
                m_resp = 1'b1;
`ifdef PIPE_RANDOM_GAP_EN
                r = tb_lfsr[8:0];
                if (r > 9'd320) r = r - 9'd321;
                m_gy = 80 + int'(r);
`else
                r = 9'd0;
                m_gy = 200 + int'(r);
`endif
            end else begin
                if (m_px >= 320 && m_px - 2 < 320) m_score = (m_score + 1) % 256;
                m_px = m_px - 2;
            end
        end
        pl  = (m_px < 27) ? 0 : m_px - 27;
        pr  = (m_px + 27 > 639) ? 639 : m_px + 27;
        ub  = (m_gy < 25) ? 0 : m_gy - 25;
        lt  = m_gy + 25;
        bb  = y + 35;
        vis = (pl < 640);
        hit = (vis && 365 >= pl && 320 <= pr && (y <= ub || bb >= lt)) || bb >= 479;
        if (hit && !m_coll) m_first = m_count;
        if (hit) m_coll = 1'b1;
        e = {19'(320), 19'(365), 19'(y), 19'(bb), 19'(pl), 19'(pr), 19'(ub),
             19'(pl), 19'(pr), 19'(lt), 19'(vis), 19'(m_coll), 19'(m_score)};
        sbq.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ivs = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bfc = 0;
        model_reset();
        sbq.delete();
    endtask

    // Drive one vsync falling edge and watch 8 cycles after the detecting edge.
    task automatic vsync_edge();
        bit   upd;
        exp_t e;
        upd = (bfc == cur_div - 1);
        bfc = upd ? 0 : bfc + 1;
        @(posedge clk); #1 ivs = 1'b0;
        @(posedge clk); #1 ivs = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (upd && c == 2) model_update();
            dut_pulses += int'(o_upd);
            vectors++;
            if (o_upd !== ((upd && c == 6) ? 1'b1 : 1'b0)) begin
                miscompares++;
                $display("FAIL oUpdate: cycle %0d after vsync got %0b expected %0b",
                         c, o_upd, (upd && c == 6));
            end
            if (upd && c == 6) begin
                n_upd++;
                if (sbq.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL scoreboard: publish with empty queue at update %0d", n_upd);
                end else begin
                    e = sbq.pop_front();
                    for (int i = 0; i < NF; i++) begin
                        vectors++;
                        if (fld(i) !== e[(NF-1-i)*19 +: 19]) begin
                            miscompares++;
                            $display("FAIL %s: got %0d expected %0d (update %0d)",
                                     fname[i], fld(i), e[(NF-1-i)*19 +: 19], n_upd);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            for (int i = 0; i < NF; i++) begin
                vectors++;
                if (fld(i) !== 19'd0) begin
                    miscompares++;
                    $display("FAIL reset_%s: dut %0d got %0d expected 0", fname[i], s, fld(i));
                end
            end
            vectors++;
            if (o_upd !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_update: dut %0d got %0b expected 0", s, o_upd);
            end
        end
    endtask

    task automatic test_first_update();
        int p0;
        sel = 1'b0; cur_div = 30; bird_y = 32'd100; irun = 1'b1;
        do_reset();
        p0 = dut_pulses;
        repeat (30) vsync_edge();
        vectors++;
        if (dut_pulses - p0 !== 1) begin
            miscompares++;
            $display("FAIL first_update_count: got %0d pulses expected 1", dut_pulses - p0);
        end
        vectors++;
        if (fld(0) !== 19'd320 || fld(1) !== 19'd365 || fld(F_BT) !== 19'd100 ||
            fld(F_BB) !== 19'd135 || fld(F_UL) !== 19'd638 || fld(F_UR) !== 19'd639 ||
            fld(F_VIS) !== 19'd1 || fld(F_COL) !== 19'd0) begin
            miscompares++;
            $display("FAIL first_update_box: got %0d/%0d/%0d/%0d pipe %0d/%0d vis %0d col %0d expected 320/365/100/135 pipe 638/639 vis 1 col 0",
                     fld(0), fld(1), fld(F_BT), fld(F_BB), fld(F_UL), fld(F_UR), fld(F_VIS), fld(F_COL));
        end
    endtask

    task automatic test_clamp();
        sel = 1'b0;
        bird_y = 32'hFFFF_FFF0;
        repeat (30) vsync_edge();
        vectors++;
        if (fld(F_BT) !== 19'd0) begin
            miscompares++;
            $display("FAIL clamp_negative: got top %0d expected 0", fld(F_BT));
        end
        bird_y = 32'd470;
        repeat (30) vsync_edge();
        vectors++;
        if (fld(F_BT) !== 19'd444 || fld(F_BB) !== 19'd479 || fld(F_COL) !== 19'd1) begin
            miscompares++;
            $display("FAIL clamp_ground: got top %0d bottom %0d col %0d expected 444 479 1",
                     fld(F_BT), fld(F_BB), fld(F_COL));
        end
    endtask

    task automatic test_score_respawn();
        int resp_seen;
        sel = 1'b1; cur_div = 1; bird_y = 32'd180; irun = 1'b1;
        do_reset();
        resp_seen = 0;
        for (int k = 1; k <= 325; k++) begin
            vsync_edge();
            if (k == 174) begin
                vectors++;
                if (fld(F_SC) !== 19'd1 || fld(F_COL) !== 19'd0) begin
                    miscompares++;
                    $display("FAIL score_174: got score %0d col %0d expected 1 0", fld(F_SC), fld(F_COL));
                end
            end
            if (m_resp) begin
                resp_seen++;
                vectors++;
                if (fld(F_UL) !== 19'd640 || fld(F_UR) !== 19'd639 ||
                    fld(F_LT) !== 19'd225 || fld(F_VIS) !== 19'd0) begin
                    miscompares++;
                    $display("FAIL respawn: got left %0d right %0d lower_top %0d vis %0d expected 640 639 225 0",
                             fld(F_UL), fld(F_UR), fld(F_LT), fld(F_VIS));
                end
            end
        end
        vectors++;
        if (resp_seen !== 1) begin
            miscompares++;
            $display("FAIL respawn_count: got %0d expected 1", resp_seen);
        end
    endtask

    task automatic test_collision_freeze();
        int dut_first;
        sel = 1'b1; cur_div = 1; bird_y = 32'd20; irun = 1'b1;
        do_reset();
        dut_first = 0;
        for (int k = 1; k <= 175; k++) begin
            vsync_edge();
            if (dut_first == 0 && fld(F_COL) === 19'd1) dut_first = k;
        end
        vectors++;
        if (dut_first !== m_first || m_first == 0) begin
            miscompares++;
            $display("FAIL collide_update: got first at %0d expected %0d", dut_first, m_first);
        end
        vectors++;
        if (fld(F_UL) !== 19'(m_px - 27) || fld(F_COL) !== 19'd1) begin
            miscompares++;
            $display("FAIL collide_freeze: got left %0d col %0d expected %0d 1",
                     fld(F_UL), fld(F_COL), m_px - 27);
        end
    endtask

    task automatic test_reset_mid_update();
        int p0;
        sel = 1'b0; cur_div = 30; bird_y = 32'd100; irun = 1'b1;
        do_reset();
        repeat (30) vsync_edge();
        repeat (29) vsync_edge();
        // 30th edge by hand: reset lands while the sequencer is in BOX
        @(posedge clk); #1 ivs = 1'b0;
        @(posedge clk); #1 ivs = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < NF; i++) begin
            vectors++;
            if (fld(i) !== 19'd0) begin
                miscompares++;
                $display("FAIL midreset_%s: got %0d expected 0", fname[i], fld(i));
            end
        end
        @(posedge clk); #1 rst = 1'b0;
        bfc = 0;
        model_reset();
        sbq.delete();
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (o_upd !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset_pulse: cycle %0d got %0b expected 0", c, o_upd);
            end
        end
        p0 = dut_pulses;
        repeat (29) vsync_edge();
        vectors++;
        if (dut_pulses - p0 !== 0) begin
            miscompares++;
            $display("FAIL midreset_early: got %0d pulses after 29 edges expected 0", dut_pulses - p0);
        end
        vsync_edge();
        vectors++;
        if (dut_pulses - p0 !== 1) begin
            miscompares++;
            $display("FAIL midreset_resume: got %0d pulses after 30 edges expected 1", dut_pulses - p0);
        end
    endtask

`ifdef PIPE_RANDOM_GAP_EN
    task automatic test_random_gap();
        int g;
        sel = 1'b1; cur_div = 1; bird_y = 32'd180; irun = 1'b1;
        do_reset();
        for (int k = 1; k <= 325; k++) begin
            vsync_edge();
            if (m_resp) begin
                g = int'(fld(F_LT)) - 25;
                vectors++;
                if (g < 80 || g > 400) begin
                    miscompares++;
                    $display("FAIL random_gap_range: got %0d expected 80..400", g);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_update();
        test_clamp();
        test_score_respawn();
        test_collision_freeze();
        test_reset_mid_update();
`ifdef PIPE_RANDOM_GAP_EN
        test_random_gap();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
